// File: rtl/pwm_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pwm_decoder_pkg : shared FSM encoding and default sizing for the PWM decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_decoder_pkg;

  localparam int DEF_R          = 8;
  localparam int DEF_TIMER_BITS = 8;
  // ~2 kHz tick from the reference system clock
  localparam int FV_2KHZ        = 195;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_decoder_if.sv
// ---------------------------------------------------------------------------
// pwm_decoder_if : control/measurement bundle between a PWM decoder and its user
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pwm_decoder_if #(
  parameter int R          = pwm_decoder_pkg::DEF_R,
  parameter int TIMER_BITS = pwm_decoder_pkg::DEF_TIMER_BITS
);
  logic [TIMER_BITS-1:0] FINAL_VALUE;
  logic                  enable;
  logic                  pwm_in;
  logic [R:0]            duty_out;
  logic                  duty_valid;
  logic                  stuck;

  modport master (
    output FINAL_VALUE, enable, pwm_in,
    input  duty_out, duty_valid, stuck
  );

  modport slave (
    input  FINAL_VALUE, enable, pwm_in,
    output duty_out, duty_valid, stuck
  );
endinterface

`default_nettype wire

// File: rtl/mod_timer.sv
// ---------------------------------------------------------------------------
// mod_timer : modulo-(FINAL_VALUE+1) prescaler emitting a one-cycle done tick
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_timer #(
  parameter int TIMER_BITS = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_en,
  input  wire logic                  i_clr,
  input  wire logic [TIMER_BITS-1:0] i_final_value,
  output logic                       o_done
);

  logic [TIMER_BITS-1:0] r_cnt;
  logic                  w_at_end;

  // >= so a lowered terminal count wraps promptly instead of running to all-ones
  assign w_at_end = (r_cnt >= i_final_value);
  assign o_done   = i_en & w_at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// pwm_decoder : measures PWM duty over 2^R prescaler ticks, flags stuck inputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int R          = DEF_R,
  parameter int TIMER_BITS = DEF_TIMER_BITS
) (
  input wire logic     clk,
  input wire logic     reset_n,
  pwm_decoder_if.slave bus
);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_sync_d;
  logic         w_rise;
  logic         w_fall;
  logic         w_tick;
  logic         w_win_last;
  logic         w_timer_en;
  logic         w_timer_clr;
  state_t       r_state;
  logic [R-1:0] r_window_cnt;
  logic [R:0]   r_high_cnt;
  logic         r_edge_seen;
  logic [R:0]   r_duty_out;
  logic         r_duty_valid;
  logic         r_stuck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= bus.pwm_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_sync_d;
  assign w_fall     = ~r_sync2 & r_sync_d;
  assign w_win_last = w_tick && (r_window_cnt == {R{1'b1}});
  assign w_timer_en = (r_state != ST_IDLE);
  // Timer is held at zero while idle and restarted on the edge that enters MEASURE
  assign w_timer_clr = (r_state == ST_IDLE) ||
                       ((r_state == ST_ARM) && (w_rise || w_win_last));

  mod_timer #(
    .TIMER_BITS (TIMER_BITS)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset_n),
    .i_en          (w_timer_en),
    .i_clr         (w_timer_clr),
    .i_final_value (bus.FINAL_VALUE),
    .o_done        (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_window_cnt <= '0;
      r_high_cnt   <= '0;
      r_edge_seen  <= 1'b0;
      r_duty_out   <= '0;
      r_duty_valid <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_window_cnt <= '0;
          r_high_cnt   <= '0;
          r_edge_seen  <= 1'b0;
          if (bus.enable) r_state <= ST_ARM;
        end
        ST_ARM: begin
          // window_cnt doubles as the rising-edge timeout counter while armed
          if (!bus.enable) begin
            r_state      <= ST_IDLE;
            r_window_cnt <= '0;
          end else if (w_rise || w_win_last) begin
            r_state      <= ST_MEASURE;
            r_window_cnt <= '0;
            r_high_cnt   <= '0;
            r_edge_seen  <= 1'b0;
          end else if (w_tick) begin
            r_window_cnt <= r_window_cnt + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_win_last) begin
            r_duty_out   <= r_high_cnt + {{R{1'b0}}, r_sync2};
            r_duty_valid <= 1'b1;
            r_stuck      <= ~(r_edge_seen | w_rise | w_fall);
            r_window_cnt <= '0;
            r_high_cnt   <= '0;
            r_edge_seen  <= 1'b0;
          end else begin
            r_edge_seen <= r_edge_seen | w_rise | w_fall;
            if (w_tick) begin
              r_window_cnt <= r_window_cnt + 1'b1;
              r_high_cnt   <= r_high_cnt + {{R{1'b0}}, r_sync2};
            end
          end
          // A window finishing on this edge is still delivered above
          if (!bus.enable) begin
            r_state      <= ST_IDLE;
            r_window_cnt <= '0;
            r_high_cnt   <= '0;
            r_edge_seen  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.duty_out   = r_duty_out;
  assign bus.duty_valid = r_duty_valid;
  assign bus.stuck      = r_stuck;

endmodule

`default_nettype wire

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder : directed self-checking bench for pwm_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_decoder;
  import pwm_decoder_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  // Reference PWM source sharing the decoder's R and FINAL_VALUE
  logic [7:0] r_pcnt;
  logic [7:0] r_gen_cnt;
  int         duty_cmd;
  logic       gen_clr;

  pwm_decoder_if #(.R(8), .TIMER_BITS(8)) bus ();

  pwm_decoder #(.R(8), .TIMER_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gen_clr) begin
      r_pcnt    <= '0;
      r_gen_cnt <= '0;
    end else if (r_pcnt >= bus.FINAL_VALUE) begin
      r_pcnt    <= '0;
      r_gen_cnt <= r_gen_cnt + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  assign bus.pwm_in = (int'(r_gen_cnt) < duty_cmd);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge on which duty_valid is seen high
  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.duty_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.duty_valid), 32'd1);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.duty_valid === 1'b1) seen++;
    end
  endtask

  initial begin
    int sweep [5];
    int n;
    int seen;
    int d;
    total           = 0;
    bad             = 0;
    sweep           = '{0, 1, 128, 255, 256};
    duty_cmd        = 0;
    gen_clr         = 1'b1;
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.FINAL_VALUE = 8'd0;

    repeat (3) @(negedge clk);
    chk("rst_duty_out", 32'(bus.duty_out), 32'd0);
    chk("rst_duty_valid", 32'(bus.duty_valid), 32'd0);
    chk("rst_stuck", 32'(bus.stuck), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // 25% duty
    reset_n    = 1'b1;
    gen_clr    = 1'b0;
    duty_cmd   = 64;
    bus.enable = 1'b1;
    wait_valid("w64_first", 1000);
    wait_valid("w64_second", 400);
    chk("duty_64", 32'(bus.duty_out), 32'd64);
    chk("stuck_64", 32'(bus.stuck), 32'd0);
    @(negedge clk);
    chk("valid_one_cycle", 32'(bus.duty_valid), 32'd0);
    n = 1;
    while (bus.duty_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("window_period", 32'(n), 32'd256);

    // Back-to-back sweep including both extremes
    foreach (sweep[k]) begin
      duty_cmd = sweep[k];
      wait_valid($sformatf("sweep%0d_settle", sweep[k]), 400);
      wait_valid($sformatf("sweep%0d_meas", sweep[k]), 400);
      chk($sformatf("sweep%0d_duty", sweep[k]), 32'(bus.duty_out), 32'(sweep[k]));
      chk($sformatf("sweep%0d_stuck", sweep[k]), 32'(bus.stuck),
          (sweep[k] == 0 || sweep[k] == 256) ? 32'd1 : 32'd0);
    end

    // Drop enable partway through a window
    duty_cmd = 128;
    wait_valid("pre_dis_settle", 400);
    wait_valid("pre_dis_meas", 400);
    repeat (100) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("dis_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    count_valid(300, seen);
    chk("dis_no_valid", 32'(seen), 32'd0);
    chk("dis_duty_hold", 32'(bus.duty_out), 32'd128);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("reen_state_arm", 32'(dut.r_state), 32'(ST_ARM));
    wait_valid("reen_window", 800);
    chk("reen_duty", 32'(bus.duty_out), 32'd128);

    // Asynchronous reset between clock edges
    repeat (50) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_duty_out", 32'(bus.duty_out), 32'd0);
    chk("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    count_valid(200, seen);
    chk("arst_no_valid", 32'(seen), 32'd0);

    // ~2 kHz tick configuration
    bus.enable      = 1'b0;
    duty_cmd        = 0;
    bus.FINAL_VALUE = 8'(FV_2KHZ);
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    duty_cmd = 192;
    gen_clr  = 1'b1;
    @(negedge clk);
    gen_clr = 1'b0;
    n = 0;
    while (dut.r_state !== ST_MEASURE && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fv_enter_measure", 32'(dut.r_state), 32'(ST_MEASURE));
    n = 0;
    while (bus.duty_valid !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("fv_window_len", 32'(n), 32'd50176);
    d = int'(bus.duty_out);
    chk("fv_duty_192", 32'(d >= 191 && d <= 193), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter R, default 8: duty resolution in bits; one measurement window = 2^R ticks.
REQ-002 Parameter TIMER_BITS, default 8: width of the tick prescaler.
REQ-003 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port FINAL_VALUE  input  TIMER_BITS: prescaler terminal count; tick period = FINAL_VALUE+1 clk cycles.
REQ-006 Port enable  input  1: high = measure; low = idle.
REQ-007 Port pwm_in  input  1: asynchronous PWM waveform to decode.
REQ-008 Port duty_out  output  R+1: last measured duty, range 0..2^R inclusive.
REQ-009 Port duty_valid  output  1: one-cycle pulse when duty_out updates.
REQ-010 Port stuck  output  1: high when the last window contained no pwm_in edge.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-012 The rising-edge and falling-edge detects SHALL compare the synchronized value against a one-cycle-delayed copy.
REQ-013 The prescaler SHALL count 0..FINAL_VALUE, assert tick for one cycle at FINAL_VALUE, and wrap to 0; FINAL_VALUE=0 SHALL give a tick every cycle.
REQ-014 The prescaler SHALL run only outside IDLE and SHALL restart at 0 on entry to MEASURE.
REQ-015 The FSM SHALL have states IDLE, ARM and MEASURE, and SHALL reset to IDLE.
REQ-016 IDLE: the FSM SHALL go to ARM on the cycle enable is sampled high.
REQ-017 ARM: the FSM SHALL go to MEASURE on the first synchronized rising edge, or after 2^R ticks with no rising edge (timeout).
REQ-018 MEASURE: on each tick, window_cnt SHALL increment, and high_cnt SHALL increment if the synchronized input is 1.
REQ-019 On the tick that completes 2^R ticks, the block SHALL load duty_out with the final high_cnt (that tick's sample included), pulse duty_valid on the next cycle, and clear both counters.
REQ-020 After a completed window the FSM SHALL stay in MEASURE, so windows run back-to-back with no gap tick.
REQ-021 high_cnt SHALL be R+1 bits wide and SHALL reach 2^R exactly at 100% duty; it SHALL NOT wrap.
REQ-022 stuck SHALL update with duty_valid: 1 if no edge of either polarity occurred during the window, else 0.
REQ-023 enable low in ARM or MEASURE SHALL force IDLE on the next cycle, discard the partial window (no duty_valid), and hold duty_out and stuck.
REQ-024 If a window completes on the same cycle enable drops, the window SHALL be delivered (duty_out, duty_valid) before the FSM enters IDLE.
REQ-025 A change of FINAL_VALUE mid-window SHALL take effect at the next prescaler wrap; the result of that window is unspecified.
REQ-026 For a source PWM generator using the same R and FINAL_VALUE, measured duty SHALL equal the programmed duty within ±1.

Reset
REQ-027 reset_n low SHALL asynchronously clear: synchronizer flops, edge-detect flop, prescaler, window_cnt, high_cnt, duty_out (0), duty_valid (0), stuck (0); FSM to IDLE.
REQ-028 Reset release SHALL be synchronous in effect; the first active edge after deassertion SHALL evaluate the IDLE transition.
REQ-029 Reset mid-window SHALL produce no duty_valid pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, default R=8, TIMER_BITS=8 and the ~2 kHz FINAL_VALUE constant 195.
REQ-031 The prescaler SHALL be a separate sub-module, mod_timer (enable, synchronous clear, FINAL_VALUE input, done tick output), reusable by the PWM generator.
REQ-032 Expected size: 120-400 lines of RTL.

Verification (R=8, FINAL_VALUE=0 unless stated)
REQ-033 Source PWM at duty 64 (25%), enable high -> after one window, duty_out=64 ±1, duty_valid 1 cycle, stuck=0; repeats every 256 ticks.
REQ-034 pwm_in held 1 -> after ARM timeout plus 256 ticks, duty_out=256, stuck=1; pwm_in held 0 -> duty_out=0, stuck=1.
REQ-035 Sweep duty 0,1,128,255,256 back-to-back -> each value reported within ±1, no duty_valid gaps beyond one window of settling.
REQ-036 enable dropped at tick 100 of a window -> no duty_valid, duty_out holds the previous value, FSM in IDLE next cycle; re-enable restarts through ARM.
REQ-037 reset_n pulsed low mid-window (asynchronous, between clock edges) -> all outputs 0 immediately, no duty_valid after release.
REQ-038 FINAL_VALUE=195, duty 192 -> window length 256*196 clk cycles, duty_out=192 ±1.
